// File: rtl/parking_pkg.sv
// Shared definitions for the parking access keypad front-end:
// key codes, entry FSM states and PIN arithmetic helpers.
package parking_pkg;

    localparam int PIN_W = 9;
    localparam int ACC_W = 10;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SUBMIT  = 2'd2
    } entry_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    // acc*10 + d using shifts; three digits top out at 999, so 10 bits never wrap.
    function automatic logic [ACC_W-1:0] times_ten_plus(input logic [ACC_W-1:0] a,
                                                        input logic [3:0]       d);
        return (a << 3) + (a << 1) + {{(ACC_W-4){1'b0}}, d};
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Inactivity timer: counts enabled cycles since the last clear and flags
// the cycle in which the terminal count is reached without a clear.
module idle_timer #(
    parameter int TERMINAL = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TERMINAL > 2) ? $clog2(TERMINAL) : 1;
    localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

    logic [CW-1:0] count;

    // Saturates at LAST so a stalled owner never sees the counter wrap.
    always_ff @(posedge clk) begin
        if (rst || clear || !enable) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && !clear && (count == LAST);

endmodule

// File: rtl/pin_entry_collector.sv
// Keypad entry collector: assembles decimal keystrokes into a binary PIN
// and hands it to the parking controller as a single-cycle strobe.
module pin_entry_collector
    import parking_pkg::*;
#(
    parameter int MAX_DIGITS     = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [PIN_W-1:0] pin_value,
    output logic             pin_valid,
    output logic             entry_error,
    output logic             entry_busy,
    output logic [1:0]       digit_count
);

    localparam logic [1:0]       MAX_CNT = 2'(MAX_DIGITS);
    localparam logic [ACC_W-1:0] PIN_MAX = ACC_W'((1 << PIN_W) - 1);

    entry_state_t     state, state_next;
    logic [ACC_W-1:0] acc, acc_next;
    logic             ovf, ovf_next;
    logic [1:0]       count_next;
    logic [PIN_W-1:0] pin_value_next;
    logic             pin_valid_next;
    logic             error_next;
    logic             timer_expired;

    idle_timer #(
        .TERMINAL(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (key_valid),
        .enable (state == ST_COLLECT),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            acc         <= '0;
            ovf         <= 1'b0;
            digit_count <= '0;
            pin_value   <= '0;
            pin_valid   <= 1'b0;
            entry_error <= 1'b0;
            entry_busy  <= 1'b0;
        end else begin
            state       <= state_next;
            acc         <= acc_next;
            ovf         <= ovf_next;
            digit_count <= count_next;
            pin_value   <= pin_value_next;
            pin_valid   <= pin_valid_next;
            entry_error <= error_next;
            entry_busy  <= (state_next != ST_IDLE);
        end
    end

    // Priority in COLLECT: disarm, then key, then timeout.
    always_comb begin
        state_next     = state;
        acc_next       = acc;
        ovf_next       = ovf;
        count_next     = digit_count;
        pin_value_next = pin_value;
        pin_valid_next = 1'b0;
        error_next     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (arm && key_valid && is_digit(key_code)) begin
                    acc_next   = {{(ACC_W-4){1'b0}}, key_code};
                    count_next = 2'd1;
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (!arm) begin
                    state_next = ST_IDLE;
                end else if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (digit_count < MAX_CNT) begin
                            acc_next   = times_ten_plus(acc, key_code);
                            count_next = digit_count + 2'd1;
                        end else begin
                            ovf_next = 1'b1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        acc_next   = '0;
                        count_next = '0;
                        ovf_next   = 1'b0;
                    end else if (key_code == KEY_ENTER) begin
                        if (ovf || (acc > PIN_MAX) || (digit_count == 2'd0)) begin
                            error_next = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            pin_value_next = acc[PIN_W-1:0];
                            pin_valid_next = 1'b1;
                            state_next     = ST_SUBMIT;
                        end
                    end
                end else if (timer_expired) begin
                    error_next = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_SUBMIT: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Every path back to IDLE throws the partial entry away.
        if (state_next == ST_IDLE) begin
            acc_next   = '0;
            count_next = '0;
            ovf_next   = 1'b0;
        end
    end

endmodule

// File: doc/pin_entry_collector.md
# pin_entry_collector

Keypad front-end for the parking access controller. Collects decimal digit keystrokes from the entry keypad, assembles them into a 9-bit binary PIN attempt, and presents it to the parking controller as a single-cycle `pin_valid` strobe with `pin_value`. Entry is accepted only while a car is detected at the gate. Incomplete, malformed or abandoned entries are discarded and flagged.

## Interface

Parameters:
- `MAX_DIGITS`, 3: maximum decimal digits accepted per entry.
- `TIMEOUT_CYCLES`, 1000: idle cycles in COLLECT before the entry is abandoned.

Ports:
- `clk`, input, 1: single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `arm`, input, 1: car present; driven from the arrival sensor. Entry is accepted only while high.
- `key_valid`, input, 1: one-cycle strobe; `key_code` is valid in that cycle.
- `key_code`, input, 4: 0–9 are digits, 4'hA is CLEAR, 4'hB is ENTER, 4'hC–4'hF are ignored.
- `pin_value`, output, 9: last committed PIN, binary. Held until the next commit.
- `pin_valid`, output, 1: one-cycle strobe; `pin_value` is new in this cycle.
- `entry_error`, output, 1: one-cycle strobe; the entry was discarded.
- `entry_busy`, output, 1: high in COLLECT and SUBMIT.
- `digit_count`, output, 2: number of digits captured in the current entry.

## Operation

- States are IDLE, COLLECT and SUBMIT.
- **Internal registers:**
  - `acc` is 10 bits.
  - `ovf` is a 1-bit flag.
  - The timer counts up to `TIMEOUT_CYCLES`.
- **IDLE:**
  - `acc` = 0, `digit_count` = 0, `ovf` = 0.
  - On `arm` and `key_valid` with a digit d: `acc` <= d, `digit_count` <= 1, go to COLLECT.
  - CLEAR, ENTER and ignored codes in IDLE produce no state change and no error.
- **COLLECT, digit d:**
  - If `digit_count` < `MAX_DIGITS`: `acc` <= `acc`*10 + d, then increment `digit_count`.
  - Otherwise: `ovf` <= 1, `acc` is unchanged.
- **COLLECT, CLEAR:** `acc` = 0, `digit_count` = 0, `ovf` = 0, stay in COLLECT. No error.
- **COLLECT, ENTER:**
  - If `ovf`, or `acc` > 511, or `digit_count` == 0: pulse `entry_error` and go to IDLE.
  - Otherwise: `pin_value` <= `acc`[8:0], go to SUBMIT.
- **COLLECT, ignored code:** no effect, except that it restarts the timer.
- **Timeout:** any `key_valid` in COLLECT resets the timer. When the timer reaches `TIMEOUT_CYCLES` - 1 with no key, pulse `entry_error` and go to IDLE.
- **Disarm:** `arm` low in COLLECT has priority over any key in the same cycle. Go to IDLE silently, with no error.
- **SUBMIT:** lasts exactly one cycle with `pin_valid` = 1, then goes to IDLE. `key_valid` in SUBMIT is dropped.
- **Arithmetic:** `acc`*10 is computed as (`acc`<<3) + (`acc`<<1) in 10 bits. The maximum, 999, fits and never wraps.

## Timing

- **Reset values:** state IDLE, `pin_value` = 0, `pin_valid` = 0, `entry_error` = 0, `entry_busy` = 0, `digit_count` = 0, timer = 0, `acc` = 0, `ovf` = 0.
- All outputs are registered.
- ENTER sampled at edge N gives `pin_valid` high in cycle N+1, with `pin_value` already updated in that cycle.
- An error from ENTER or timeout decided at edge N gives `entry_error` high in cycle N+1. The state is IDLE from the same edge.
- Keys may arrive on back-to-back cycles. Each `key_valid` cycle is processed exactly once.
- `rst` asserted mid-entry discards the entry. No `pin_valid` or `entry_error` strobe is emitted.
- `pin_valid` and `entry_error` are never high in the same cycle.

## Structure

- **Shared package (`parking_pkg`):**
  - Key code constants: `KEY_CLEAR` = 4'hA, `KEY_ENTER` = 4'hB.
  - State enum for IDLE, COLLECT, SUBMIT.
  - `PIN_W` = 9.
- **Sub-module `idle_timer`:**
  - Parameterised terminal count.
  - Inputs: `clk`, `rst`, `clear`, `enable`.
  - Output: a one-cycle `expired` pulse.
  - Instantiated once, enabled only in COLLECT.

## Test plan

- **Valid entry.** Stimulus: `arm`=1, keys 8, 7, ENTER. Response: `pin_valid` for one cycle with `pin_value` = 9'd87, one cycle after ENTER. `entry_busy` falls after SUBMIT.
- **Out-of-range PIN.** Stimulus: keys 6, 0, 0, ENTER (600 > 511). Response: `entry_error` pulse, no `pin_valid`, `pin_value` keeps its previous value.
- **Overflow then clear.** Stimulus: keys 1, 2, 3, 4, ENTER. Response: error, because `ovf` is set. Then keys 1, 2, CLEAR, 5, ENTER. Response: `pin_valid` with `pin_value` = 5.
- **Timeout with `TIMEOUT_CYCLES` = 16.** Stimulus: key 3, then no keys. Response: `entry_error` exactly 16 cycles after the key; `digit_count` returns to 0.
- **Disarm vs ENTER.** Stimulus: drop `arm` in the same cycle as ENTER after keys 4, 2. Response: no `pin_valid`, no `entry_error`, state IDLE.
- **Mid-entry reset and SUBMIT drop.** Stimulus: assert `rst` after key 9. Response: all outputs at reset values next cycle. Stimulus: key 5 presented during SUBMIT. Response: it is dropped, and the next entry starts from IDLE.
